// File: rtl/gpio_in_debounce.sv
// Per-pin pad conditioning: two-flop synchronizer followed by a programmable
// debounce filter, producing a clean level plus registered rise/fall pulses.
module gpio_in_debounce #(
   parameter int unsigned          NumGpio  = 20,
   parameter int unsigned          CntW     = 16,
   parameter logic [NumGpio-1:0]   ResetVal = '0
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NumGpio-1:0]  gpio_i,
   input  logic [CntW-1:0]     debounce_cycles_i,
   input  logic                bypass_i,
   output logic [NumGpio-1:0]  gpio_o,
   output logic [NumGpio-1:0]  rise_o,
   output logic [NumGpio-1:0]  fall_o,
   output logic                any_edge_o
);

   logic [NumGpio-1:0]            r_s1;
   logic [NumGpio-1:0]            r_s2;
   logic [NumGpio-1:0]            r_stable;
   logic [NumGpio-1:0][CntW-1:0]  r_cnt;
   logic [NumGpio-1:0]            r_rise;
   logic [NumGpio-1:0]            r_fall;
   logic                          r_any;

   logic [CntW-1:0]               w_neff;
   logic [NumGpio-1:0]            w_stable_nxt;
   logic [NumGpio-1:0][CntW-1:0]  w_cnt_nxt;
   logic [NumGpio-1:0]            w_rise_nxt;
   logic [NumGpio-1:0]            w_fall_nxt;
   logic                          w_any_nxt;

   // Effective threshold: zero is treated as a single-cycle filter.
   always_comb begin
      w_neff = debounce_cycles_i;
      if (debounce_cycles_i == {CntW{1'b0}}) begin
         w_neff = {{(CntW-1){1'b0}}, 1'b1};
      end else begin
         w_neff = debounce_cycles_i;
      end
   end

   // Per-bit filter next state; the threshold compare is one bit wider so it never wraps.
   always_comb begin
      w_stable_nxt = r_stable;
      w_cnt_nxt    = r_cnt;
      for (int i = 0; i < int'(NumGpio); i++) begin
         if (bypass_i) begin
            w_stable_nxt[i] = r_s2[i];
            w_cnt_nxt[i]    = {CntW{1'b0}};
         end else if (r_s2[i] == r_stable[i]) begin
            w_stable_nxt[i] = r_stable[i];
            w_cnt_nxt[i]    = {CntW{1'b0}};
         end else if (({1'b0, r_cnt[i]} + {{CntW{1'b0}}, 1'b1}) >= {1'b0, w_neff}) begin
            w_stable_nxt[i] = r_s2[i];
            w_cnt_nxt[i]    = {CntW{1'b0}};
         end else begin
            w_stable_nxt[i] = r_stable[i];
            w_cnt_nxt[i]    = r_cnt[i] + {{(CntW-1){1'b0}}, 1'b1};
         end
      end
   end

   // Edge detection on the stable level, aligned with its update.
   always_comb begin
      w_rise_nxt = w_stable_nxt & ~r_stable;
      w_fall_nxt = ~w_stable_nxt & r_stable;
      w_any_nxt  = |(w_rise_nxt | w_fall_nxt);
   end

   // State registers with synchronous active-low reset; a reset discards any partial count.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_s1     <= ResetVal;
         r_s2     <= ResetVal;
         r_stable <= ResetVal;
         r_cnt    <= '0;
         r_rise   <= {NumGpio{1'b0}};
         r_fall   <= {NumGpio{1'b0}};
         r_any    <= 1'b0;
      end else begin
         r_s1     <= gpio_i;
         r_s2     <= r_s1;
         r_stable <= w_stable_nxt;
         r_cnt    <= w_cnt_nxt;
         r_rise   <= w_rise_nxt;
         r_fall   <= w_fall_nxt;
         r_any    <= w_any_nxt;
      end
   end

   assign gpio_o     = r_stable;
   assign rise_o     = r_rise;
   assign fall_o     = r_fall;
   assign any_edge_o = r_any;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed self-checking bench for gpio_in_debounce: reset, filter timing,
// bounce rejection, zero threshold, bypass, threshold change and max threshold.
module tb_gpio_in_debounce;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic [19:0]   gpio_i;
   logic [15:0]   debounce_cycles_i;
   logic          bypass_i;
   logic [19:0]   gpio_o;
   logic [19:0]   rise_o;
   logic [19:0]   fall_o;
   logic          any_edge_o;

   int n_checks = 0;
   int n_fail   = 0;

   gpio_in_debounce #(.NumGpio(20), .CntW(16), .ResetVal(20'h00000)) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .gpio_i            (gpio_i),
      .debounce_cycles_i (debounce_cycles_i),
      .bypass_i          (bypass_i),
      .gpio_o            (gpio_o),
      .rise_o            (rise_o),
      .fall_o            (fall_o),
      .any_edge_o        (any_edge_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      gpio_i = 20'h00000;
      bypass_i = 1'b0;
      repeat (3) tick();
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      gpio_i = 20'hFFFFF;
      bypass_i = 1'b0;
      debounce_cycles_i = 16'd4;
      repeat (3) tick();
      n_checks++;
      if (gpio_o !== 20'h00000 || rise_o !== 20'h00000 || fall_o !== 20'h00000 || any_edge_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: gpio_o=%h rise=%h fall=%h any=%b, want all 0", gpio_o, rise_o, fall_o, any_edge_o);
      end
      rst_ni = 1'b1;
      repeat (5) tick();
      n_checks++;
      if (gpio_o !== 20'h00000 || rise_o !== 20'h00000) begin
         n_fail++;
         $display("FAIL reset_early: gpio_o=%h rise=%h at t0+4, want 0 0", gpio_o, rise_o);
      end
      tick();
      n_checks++;
      if (gpio_o !== 20'hFFFFF || rise_o !== 20'hFFFFF || any_edge_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: gpio_o=%h rise=%h any=%b at t0+5, want fffff fffff 1", gpio_o, rise_o, any_edge_o);
      end
      tick();
      n_checks++;
      if (gpio_o !== 20'hFFFFF || rise_o !== 20'h00000 || any_edge_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pulse_width: gpio_o=%h rise=%h any=%b, want fffff 0 0", gpio_o, rise_o, any_edge_o);
      end
   endtask

   task automatic test_basic();
      do_reset();
      debounce_cycles_i = 16'd3;
      gpio_i = 20'h00001;
      repeat (4) tick();
      n_checks++;
      if (gpio_o !== 20'h00000 || rise_o !== 20'h00000) begin
         n_fail++;
         $display("FAIL basic_early: gpio_o=%h rise=%h at t0+3, want 0 0", gpio_o, rise_o);
      end
      tick();
      n_checks++;
      if (gpio_o !== 20'h00001 || rise_o !== 20'h00001 || fall_o !== 20'h00000 || any_edge_o !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_update: gpio_o=%h rise=%h fall=%h any=%b, want 1 1 0 1", gpio_o, rise_o, fall_o, any_edge_o);
      end
      tick();
      n_checks++;
      if (gpio_o !== 20'h00001 || rise_o !== 20'h00000 || any_edge_o !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_pulse_width: gpio_o=%h rise=%h any=%b, want 1 0 0", gpio_o, rise_o, any_edge_o);
      end
   endtask

   task automatic test_bounce();
      logic [7:0] pat;
      int first_hi;
      int n_rise;
      pat = 8'b1111_0111;   // applied LSB first: 1,1,1,0,1,1,1,1
      first_hi = 0;
      n_rise = 0;
      do_reset();
      debounce_cycles_i = 16'd4;
      for (int j = 1; j <= 14; j++) begin
         gpio_i[5] = (j <= 8) ? pat[j-1] : 1'b1;
         tick();
         if (rise_o[5]) n_rise++;
         if (gpio_o[5] && first_hi == 0) first_hi = j;
      end
      n_checks++;
      if (first_hi != 10) begin
         n_fail++;
         $display("FAIL bounce_latency: gpio_o[5] first high after tick %0d, want 10", first_hi);
      end
      n_checks++;
      if (n_rise != 1) begin
         n_fail++;
         $display("FAIL bounce_pulses: %0d rise pulses on bit 5, want 1", n_rise);
      end
      n_checks++;
      if (gpio_o !== 20'h00020) begin
         n_fail++;
         $display("FAIL bounce_final: gpio_o=%h, want 00020", gpio_o);
      end
   endtask

   task automatic test_zero_bypass();
      int n_any;
      do_reset();
      debounce_cycles_i = 16'd0;
      gpio_i = 20'h00002;
      repeat (2) tick();
      n_checks++;
      if (gpio_o !== 20'h00000) begin
         n_fail++;
         $display("FAIL n0_early: gpio_o=%h at t0+1, want 0", gpio_o);
      end
      tick();
      n_checks++;
      if (gpio_o !== 20'h00002 || rise_o !== 20'h00002) begin
         n_fail++;
         $display("FAIL n0_update: gpio_o=%h rise=%h at t0+2, want 2 2", gpio_o, rise_o);
      end
      debounce_cycles_i = 16'd1;
      gpio_i = 20'h00000;
      repeat (2) tick();
      n_checks++;
      if (gpio_o !== 20'h00002 || fall_o !== 20'h00000) begin
         n_fail++;
         $display("FAIL n1_early: gpio_o=%h fall=%h at t0+1, want 2 0", gpio_o, fall_o);
      end
      tick();
      n_checks++;
      if (gpio_o !== 20'h00000 || fall_o !== 20'h00002 || rise_o !== 20'h00000) begin
         n_fail++;
         $display("FAIL n1_update: gpio_o=%h fall=%h rise=%h at t0+2, want 0 2 0", gpio_o, fall_o, rise_o);
      end
      // single-cycle pad pulse in bypass with a long threshold programmed
      debounce_cycles_i = 16'd50;
      bypass_i = 1'b1;
      tick();
      gpio_i = 20'h00004;
      tick();
      gpio_i = 20'h00000;
      tick();
      n_checks++;
      if (gpio_o !== 20'h00000) begin
         n_fail++;
         $display("FAIL bypass_early: gpio_o=%h at t0+1, want 0", gpio_o);
      end
      tick();
      n_checks++;
      if (gpio_o !== 20'h00004 || rise_o !== 20'h00004 || any_edge_o !== 1'b1) begin
         n_fail++;
         $display("FAIL bypass_rise: gpio_o=%h rise=%h any=%b at t0+2, want 4 4 1", gpio_o, rise_o, any_edge_o);
      end
      tick();
      n_checks++;
      if (gpio_o !== 20'h00000 || fall_o !== 20'h00004 || rise_o !== 20'h00000) begin
         n_fail++;
         $display("FAIL bypass_fall: gpio_o=%h fall=%h rise=%h at t0+3, want 0 4 0", gpio_o, fall_o, rise_o);
      end
      bypass_i = 1'b0;
      n_any = 0;
      repeat (6) begin
         tick();
         if (any_edge_o) n_any++;
      end
      n_checks++;
      if (n_any != 0 || gpio_o !== 20'h00000) begin
         n_fail++;
         $display("FAIL bypass_exit: %0d edges, gpio_o=%h, want 0 edges and 0", n_any, gpio_o);
      end
   endtask

   task automatic test_thresh_change();
      do_reset();
      debounce_cycles_i = 16'd100;
      gpio_i = 20'h00008;
      repeat (12) tick();
      n_checks++;
      if (gpio_o !== 20'h00000 || rise_o !== 20'h00000) begin
         n_fail++;
         $display("FAIL thr_hold: gpio_o=%h rise=%h with N=100, want 0 0", gpio_o, rise_o);
      end
      debounce_cycles_i = 16'd5;
      tick();
      n_checks++;
      if (gpio_o !== 20'h00008 || rise_o !== 20'h00008) begin
         n_fail++;
         $display("FAIL thr_lowered: gpio_o=%h rise=%h, want 8 8", gpio_o, rise_o);
      end
      tick();
      n_checks++;
      if (gpio_o !== 20'h00008 || rise_o !== 20'h00000) begin
         n_fail++;
         $display("FAIL thr_single_pulse: gpio_o=%h rise=%h, want 8 0", gpio_o, rise_o);
      end
   endtask

   task automatic test_multi_max();
      int n_any;
      int n_bad;
      do_reset();
      debounce_cycles_i = 16'hFFFF;
      gpio_i = 20'h80081;
      n_any = 0;
      n_bad = 0;
      for (int j = 1; j <= 65536; j++) begin
         tick();
         if (any_edge_o) n_any++;
         if (gpio_o !== 20'h00000) n_bad++;
      end
      n_checks++;
      if (n_any != 0 || n_bad != 0) begin
         n_fail++;
         $display("FAIL max_early: %0d edges, %0d early updates before t0+65536, want 0 0", n_any, n_bad);
      end
      tick();
      n_checks++;
      if (gpio_o !== 20'h80081 || rise_o !== 20'h80081 || any_edge_o !== 1'b1) begin
         n_fail++;
         $display("FAIL max_update: gpio_o=%h rise=%h any=%b, want 80081 80081 1", gpio_o, rise_o, any_edge_o);
      end
      tick();
      n_checks++;
      if (any_edge_o !== 1'b0 || rise_o !== 20'h00000 || gpio_o !== 20'h80081) begin
         n_fail++;
         $display("FAIL max_single_pulse: any=%b rise=%h gpio_o=%h, want 0 0 80081", any_edge_o, rise_o, gpio_o);
      end
   endtask

   initial begin
      rst_ni = 1'b0;
      gpio_i = 20'h00000;
      debounce_cycles_i = 16'd4;
      bypass_i = 1'b0;
      test_reset();
      test_basic();
      test_bounce();
      test_zero_bypass();
      test_thresh_change();
      test_multi_max();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gpio_in_debounce.md
# gpio_in_debounce

Per-pin input conditioning stage that sits directly upstream of the `gpio` peripheral, between the SoC `gpio_i` pads and the `cio_gpio_i` input of the GPIO block. Each pad bit goes through a two-flop synchronizer and then a programmable-length debounce filter. The block emits a clean, glitch-free level per pin, plus single-cycle rise/fall event pulses. It removes metastability and contact bounce from the pads before the GPIO block's own edge/interrupt logic sees them.

## Interface
Parameters:
- `NumGpio`, default 20: number of pad bits conditioned.
- `CntW`, default 16: width of each per-pin debounce counter and of the threshold input.
- `ResetVal`, default 0: reset value of the synchronizer stages and of the stable level, applied per bit (width `NumGpio`).

Ports:
- `clk_i`, in, 1: single clock. All state is in this domain.
- `rst_ni`, in, 1: reset, synchronous and active-low.
- `gpio_i`, in, NumGpio: raw asynchronous pad inputs.
- `debounce_cycles_i`, in, CntW: filter length N, quasi-static. A value of 0 is treated as 1.
- `bypass_i`, in, 1: 1 = filter disabled, so the output follows the synchronized input.
- `gpio_o`, out, NumGpio: debounced stable level. Feeds `cio_gpio_i`.
- `rise_o`, out, NumGpio: one-cycle pulse when a bit of `gpio_o` goes 0→1.
- `fall_o`, out, NumGpio: one-cycle pulse when a bit of `gpio_o` goes 1→0.
- `any_edge_o`, out, 1: OR-reduction of `rise_o | fall_o`, registered together with the pulses.

## Operation
- Per bit i, the state is: `s1`, `s2` (synchronizer), `stable`, `cnt[CntW-1:0]`, `rise_q`, `fall_q`.
- Synchronizer: on each clock edge, `s1` ← `gpio_i`, then `s2` ← `s1`. No other logic samples `gpio_i`.
- Effective threshold: Neff = (`debounce_cycles_i` == 0) ? 1 : `debounce_cycles_i`. The comparison `cnt + 1 >= Neff` is evaluated at CntW+1 bits, so it never wraps.
- Filter, evaluated each cycle with `bypass_i` = 0:
  - If `s2` == `stable`: `cnt` ← 0.
  - Else if `cnt + 1 >= Neff`: `stable` ← `s2`, `cnt` ← 0, and the matching edge pulse fires.
  - Else: `cnt` ← `cnt + 1`.
- A disagreement must persist for Neff consecutive cycles. Any single cycle of agreement restarts the count from 0.
- Bypass (`bypass_i` = 1):
  - `stable` ← `s2` every cycle and `cnt` ← 0.
  - Edge pulses still fire on every change of `stable`.
  - Synchronization is never bypassed.
- Edge pulses: `rise_q` ← (`stable` becomes 1 this edge), `fall_q` ← (`stable` becomes 0 this edge). Both are cleared the next cycle unless another transition occurs.
- `any_edge_o` ← OR over all bits of the next-state `rise|fall`, so it is aligned with `rise_o`/`fall_o`.
- Threshold change mid-count: the new Neff is used immediately. If `cnt + 1 >= ` new Neff, `stable` updates on that same edge. Counters are not cleared by a threshold change.
- Bypass deasserted mid-operation: the filter resumes with `cnt` = 0 and `stable` = the current `s2`. No spurious edge is produced.
- All bits are independent. Simultaneous transitions on several bits produce simultaneous pulses, and `any_edge_o` is a single pulse.

## Timing
- Reset (`rst_ni` low at a clock edge):
  - `s1`, `s2`, `stable` ← `ResetVal`.
  - `cnt` ← 0, `rise_o` = `fall_o` = 0, `any_edge_o` = 0.
  - `gpio_o` = `ResetVal`.
  - Reset mid-count discards the partial count and produces no pulse.
- After reset, a pad held at the opposite of `ResetVal` is filtered normally and produces one edge pulse.
- Latency, filter mode: the pad value is captured into `s1` at edge t0, reaches `s2` at t0+1, and `stable`/`gpio_o` plus the pulse update at edge t0+Neff+1. `gpio_o` is valid Neff+1 cycles after capture.
- Latency, bypass mode: `gpio_o` updates at t0+2.
- Pulse width is exactly one cycle. A bit cannot pulse on consecutive cycles in filter mode when Neff ≥ 2.
- Maximum N = 2^CntW − 1 = 65535 by default, with no overflow.
- All outputs are registered. There is no combinational path from `gpio_i`, `debounce_cycles_i` or `bypass_i` to any output.

## Test plan
- Reset: hold `rst_ni` = 0 for 3 cycles with `gpio_i` = 20'hFFFFF, ResetVal = 0. Then `gpio_o` = 0 and there are no pulses. Release with N = 4: `gpio_o` = 20'hFFFFF and `rise_o` = 20'hFFFFF for exactly one cycle, both at edge t0+5.
- Basic debounce: N = 3, bit 0 steps 0→1 and holds. `gpio_o[0]` = 1 on edge t0+4, `rise_o[0]` is high one cycle, `any_edge_o` is high one cycle.
- Bounce rejection: N = 4, bit 5 pattern 1,1,1,0,1,1,1,1 (one value per cycle). The glitch resets the count. `gpio_o[5]` rises only after the final 4-cycle run, and exactly one `rise_o[5]` pulse occurs.
- Zero/one threshold and bypass:
  - N = 0 behaves identically to N = 1 (update at t0+2).
  - With `bypass_i` = 1, a single-cycle pad pulse appears on `gpio_o` two cycles later, with a `rise_o` then a `fall_o` pulse.
- Threshold lowered mid-count: N = 100, hold bit 3 changed for 10 cycles, then set N = 5. `gpio_o[3]` updates on the next edge, with a single pulse.
- Multi-bit and maximum: bits 0, 7 and 19 change on the same edge with N = 65535. All three update together after 65536 cycles. There is one `any_edge_o` pulse and no counter wrap.
